// File: rtl/sz_block_framer.sv
// sz_block_framer
// ---------------------------------------------------------------------------
// Pops 64-bit words from the SZ ping-pong merger's FWFT output and groups them
// into blocks of BLOCK_WORDS data words. Each block is closed by a trailer
// word {8'hA5, seq[7:0], count[15:0], chk[31:0]} flagged with out_last=1.
// A flush pulse closes the current partial block once the input runs dry;
// a flush with no partial block emits nothing and just retires.
//
// Optional feature macro: SZ_FRAMER_CHECKSUM_EN
//   defined   : chk folds every data word (chk ^= w[63:32] ^ w[31:0])
//   undefined : no checksum logic, trailer [31:0] = 32'h0
//
// Parameters:
//   BLOCK_WORDS  data words per full block (1..65535)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data/in_valid    merger FWFT word and presence flag
//   in_read             pop strobe (combinational), word consumed on the edge
//   flush / flush_done  close-partial-block request / one-cycle retire pulse
//   out_data/valid/last registered output stream word, last = trailer
//   out_ready           consumer accept
//   blocks_sent         trailers accepted by the consumer (wraps)
//   busy                block in progress, trailer pending, output or flush pending
// ---------------------------------------------------------------------------
module sz_block_framer #(
    parameter int BLOCK_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_read,
    input  logic        flush,
    output logic        flush_done,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] blocks_sent,
    output logic        busy
);

    typedef enum logic [0:0] {
        ST_DATA    = 1'b0,
        ST_TRAILER = 1'b1
    } state_t;

    localparam logic [15:0] BLOCK_WORDS_C = BLOCK_WORDS[15:0];

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  seq_q, seq_d;
    logic        flush_pending_q, flush_pending_d;
    logic        flush_done_q, flush_done_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [15:0] blocks_sent_q, blocks_sent_d;
    logic        in_read_s;
    logic        slot_free_s;
    logic [31:0] chk_s;

`ifdef SZ_FRAMER_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;
    assign chk_s = chk_q;
`else
    assign chk_s = 32'h0;
`endif

    // The output register can take a new word when empty or being drained.
    assign slot_free_s = ~out_valid_q | out_ready;

    // Framing FSM: next state, block bookkeeping and output register load.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        seq_d           = seq_q;
        flush_pending_d = flush_pending_q;
        flush_done_d    = 1'b0;
        out_data_d      = out_data_q;
        out_last_d      = out_last_q;
        in_read_s       = 1'b0;
`ifdef SZ_FRAMER_CHECKSUM_EN
        chk_d           = chk_q;
`endif
        // A handshaken word leaves the register unless reloaded below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            ST_DATA: begin
                if (in_valid && slot_free_s) begin
                    in_read_s   = 1'b1;
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    count_d     = count_q + 16'd1;
`ifdef SZ_FRAMER_CHECKSUM_EN
                    chk_d       = chk_q ^ in_data[63:32] ^ in_data[31:0];
`endif
                    if ((count_q + 16'd1) == BLOCK_WORDS_C) begin
                        state_d = ST_TRAILER;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else if (flush_pending_q && !in_valid) begin
                    // Input is dry: close the partial block, or retire an
                    // empty flush without emitting an empty block.
                    if (count_q != 16'd0) begin
                        state_d = ST_TRAILER;
                    end else begin
                        flush_pending_d = 1'b0;
                        flush_done_d    = 1'b1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_TRAILER: begin
                if (slot_free_s) begin
                    out_data_d  = {8'hA5, seq_q, count_q, chk_s};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
                    count_d     = 16'd0;
                    seq_d       = seq_q + 8'd1;
`ifdef SZ_FRAMER_CHECKSUM_EN
                    chk_d       = 32'h0;
`endif
                    // Any trailer, natural or flushed, retires a pending flush.
                    if (flush_pending_q) begin
                        flush_pending_d = 1'b0;
                        flush_done_d    = 1'b1;
                    end else begin
                        flush_pending_d = flush_pending_q;
                    end
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_TRAILER;
                end
            end
            default: begin
                state_d = ST_DATA;
            end
        endcase

        // New requests merge into an outstanding one.
        flush_pending_d = flush_pending_d | flush;
    end

    // Trailer handshake counter.
    always_comb begin
        if (out_valid_q && out_ready && out_last_q) begin
            blocks_sent_d = blocks_sent_q + 16'd1;
        end else begin
            blocks_sent_d = blocks_sent_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_DATA;
            count_q         <= 16'd0;
            seq_q           <= 8'd0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
            out_data_q      <= 64'd0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            blocks_sent_q   <= 16'd0;
`ifdef SZ_FRAMER_CHECKSUM_EN
            chk_q           <= 32'h0;
`endif
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            seq_q           <= seq_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
            out_data_q      <= out_data_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            blocks_sent_q   <= blocks_sent_d;
`ifdef SZ_FRAMER_CHECKSUM_EN
            chk_q           <= chk_d;
`endif
        end
    end

    assign in_read     = in_read_s;
    assign flush_done  = flush_done_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign blocks_sent = blocks_sent_q;
    assign busy        = (count_q != 16'd0) | (state_q == ST_TRAILER) |
                         out_valid_q | flush_pending_q;

endmodule

// File: tb/tb_sz_block_framer.sv
// Testbench for sz_block_framer with BLOCK_WORDS=4. A queue-based block model
// predicts the framed stream from accepted input words and flush requests;
// a single negedge process compares every handshaken output word, stall
// stability, blocks_sent and flush_done against it.
module tb_sz_block_framer;

    localparam int BW = 4;
`ifdef SZ_FRAMER_CHECKSUM_EN
    localparam logic [31:0] CHK1 = 32'h00000004;  // 1^2^3^4
    localparam logic [31:0] CHK2 = 32'h00000008;  // 9^10^11
    localparam logic [31:0] CHK3 = 32'h0000000C;  // 21^22^23^24
`else
    localparam logic [31:0] CHK1 = 32'h0;
    localparam logic [31:0] CHK2 = 32'h0;
    localparam logic [31:0] CHK3 = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_read;
    logic        flush;
    logic        flush_done;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic [15:0] blocks_sent;
    logic        busy;

    sz_block_framer #(.BLOCK_WORDS(BW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_read(in_read), .flush(flush), .flush_done(flush_done),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .blocks_sent(blocks_sent), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // stimulus source and knobs
    logic [63:0] src[$];
    int          valid_pct = 100;
    int          rdy_pct = 100;
    logic        drv_fire = 1'b0;

    // model state
    logic [64:0] exp_q[$];
    logic [64:0] out_log[$];
    int          m_count = 0;
    logic [31:0] m_chk = 32'h0;
    logic [7:0]  m_seq = 8'h0;
    logic        m_pending = 1'b0;
    logic [15:0] m_blocks = 16'h0;
    int          exp_fd = 0;
    int          obs_fd = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] held_data;
    logic        held_last;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [64:0] trailer(input logic [7:0] s, input logic [15:0] c,
                                            input logic [31:0] k);
        return {1'b1, 8'hA5, s, c, k};
    endfunction

    task automatic model_close();
        exp_q.push_back(trailer(m_seq, 16'(m_count), m_chk));
        m_seq = m_seq + 8'd1;
        m_count = 0;
        m_chk = 32'h0;
        if (m_pending) begin
            m_pending = 1'b0;
            exp_fd++;
        end
    endtask

    // Compare and model-update process, runs on values about to be clocked in.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_count = 0; m_chk = 32'h0; m_seq = 8'h0; m_pending = 1'b0;
            m_blocks = 16'h0; prev_stall = 1'b0; drv_fire = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {64'd0, out_valid}, {64'd0, 1'b1});
                check("stall_hold", {out_last, out_data}, {held_last, held_data});
            end
            prev_stall = out_valid & ~out_ready;
            held_data = out_data;
            held_last = out_last;
            check("blocks_sent", {49'd0, blocks_sent}, {49'd0, m_blocks});
            if (in_read && !in_valid) check("read_without_valid", 65'd1, 65'd0);
            if (flush_done) obs_fd++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {out_last, out_data}, 65'd0);
                end else begin
                    check("stream_word", {out_last, out_data}, exp_q.pop_front());
                end
                out_log.push_back({out_last, out_data});
                if (out_last) m_blocks = m_blocks + 16'd1;
            end
            drv_fire = in_valid & in_read;
            if (drv_fire) begin
                exp_q.push_back({1'b0, in_data});
                m_count++;
`ifdef SZ_FRAMER_CHECKSUM_EN
                m_chk = m_chk ^ in_data[63:32] ^ in_data[31:0];
`endif
                if (m_count == BW) model_close();
            end else if (m_pending && !in_valid) begin
                if (m_count != 0) begin
                    model_close();
                end else begin
                    m_pending = 1'b0;
                    exp_fd++;
                end
            end
            if (flush) m_pending = 1'b1;
        end
    end

    // Input/ready driver: FWFT source from the src queue plus random gating.
    initial begin
        in_valid = 1'b0;
        in_data = 64'd0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (drv_fire && src.size() > 0) void'(src.pop_front());
            in_valid = (src.size() > 0) && ($urandom_range(0, 99) < valid_pct);
            in_data = (src.size() > 0) ? src[0] : 64'd0;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    task automatic drain();
        int n = 0;
        while ((src.size() != 0 || exp_q.size() != 0 || out_valid) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("drain_timeout", 65'd1, 65'd0);
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk);
        #2 flush = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        src.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int fd0;
        int bad;
        int trl;
        rst = 1'b1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {64'd0, out_valid}, 65'd0);
        check("rst_out_last", {64'd0, out_last}, 65'd0);
        check("rst_out_data", {1'b0, out_data}, 65'd0);
        check("rst_in_read", {64'd0, in_read}, 65'd0);
        check("rst_flush_done", {64'd0, flush_done}, 65'd0);
        check("rst_blocks_sent", {49'd0, blocks_sent}, 65'd0);
        check("rst_busy", {64'd0, busy}, 65'd0);
        #2 rst = 1'b0;

        // two full blocks of 1..8 back-to-back
        base = out_log.size();
        for (int i = 1; i <= 8; i++) src.push_back(64'(i));
        drain();
        check("t1_len", 65'(out_log.size() - base), 65'd10);
        check("t1_w0", out_log[base], {1'b0, 64'd1});
        check("t1_w3", out_log[base + 3], {1'b0, 64'd4});
        check("t1_trl0", out_log[base + 4], {1'b1, 8'hA5, 8'h00, 16'h0004, CHK1});
        check("t1_w5", out_log[base + 5], {1'b0, 64'd5});
        check("t1_trl1_hi", {32'd0, out_log[base + 9][64:32]}, {32'd0, 1'b1, 32'hA5010004});
        check("t1_blocks", {49'd0, blocks_sent}, 65'd2);

        // partial block closed by flush once input is dry
        base = out_log.size();
        fd0 = obs_fd;
        for (int i = 9; i <= 11; i++) src.push_back(64'(i));
        drain();
        pulse_flush();
        drain();
        check("t2_len", 65'(out_log.size() - base), 65'd4);
        check("t2_trl", out_log[base + 3], {1'b1, 8'hA5, 8'h02, 16'h0003, CHK2});
        check("t2_flush_done", 65'(obs_fd - fd0), 65'd1);

        // empty flush: no word, one flush_done, seq unchanged
        base = out_log.size();
        fd0 = obs_fd;
        pulse_flush();
        drain();
        check("t3_len", 65'(out_log.size() - base), 65'd0);
        check("t3_flush_done", 65'(obs_fd - fd0), 65'd1);
        for (int i = 12; i <= 15; i++) src.push_back(64'(i));
        drain();
        check("t3_seq", {57'd0, out_log[base + 4][55:48]}, 65'h03);

        // randomized traffic with 50% backpressure
        base = out_log.size();
        valid_pct = 70;
        rdy_pct = 50;
        for (int i = 0; i < 1000; i++) src.push_back({$urandom, $urandom});
        drain();
        valid_pct = 100;
        rdy_pct = 100;
        check("t4_len", 65'(out_log.size() - base), 65'd1250);
        bad = 0;
        trl = 0;
        for (int i = 0; i < out_log.size() - base; i++) begin
            if (out_log[base + i][64] != ((i % 5) == 4)) bad++;
            if (out_log[base + i][64]) trl++;
        end
        check("t4_trailer_pos", 65'(bad), 65'd0);
        check("t4_trailers", 65'(trl), 65'd250);

        // reset mid-block with count=2
        src.push_back(64'hAA);
        src.push_back(64'hBB);
        while (src.size() != 0) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", {64'd0, out_valid}, 65'd0);
        check("mid_rst_data", {out_last, out_data}, 65'd0);
        check("mid_rst_blocks", {49'd0, blocks_sent}, 65'd0);
        check("mid_rst_busy", {62'd0, busy, flush_done, in_read}, 65'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        base = out_log.size();
        for (int i = 21; i <= 24; i++) src.push_back(64'(i));
        drain();
        check("t5_len", 65'(out_log.size() - base), 65'd5);
        check("t5_trl", out_log[base + 4], {1'b1, 8'hA5, 8'h00, 16'h0004, CHK3});
        check("t5_blocks", {49'd0, blocks_sent}, 65'd1);

        // seq wrap over 257 full blocks
        do_reset();
        base = out_log.size();
        for (int i = 0; i < 257 * BW; i++) src.push_back(64'(i + 1000));
        drain();
        check("t6_len", 65'(out_log.size() - base), 65'(257 * 5));
        check("t6_seq_wrap", {57'd0, out_log[base + 257 * 5 - 1][55:48]}, 65'h00);
        check("t6_last", {64'd0, out_log[base + 257 * 5 - 1][64]}, 65'd1);
        check("t6_blocks", {49'd0, blocks_sent}, 65'd257);
        check("idle_busy", {64'd0, busy}, 65'd0);
        check("flush_done_total", 65'(obs_fd), 65'(exp_fd));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
